// File: rtl/nv_nvdla_cdma_wt_rd_req_mux_pkg.sv
// Shared constants for the CDMA weight read-request mux:
// payload width, source tags and the outstanding-read limit.
package nv_nvdla_cdma_wt_rd_req_mux_pkg;

  localparam int CDMA_WT_RD_PD_W    = 79;
  localparam int CDMA_WT_MAX_OUTSTD = 128;
  localparam int CDMA_WT_CNT_W      = $clog2(CDMA_WT_MAX_OUTSTD + 1);

  localparam logic SRC_WT  = 1'b0;
  localparam logic SRC_WMB = 1'b1;

endpackage

// File: rtl/nv_nvdla_cdma_wt_outstd_cnt.sv
// Per-source outstanding-read counter: +1 on issue, -1 on return,
// full flag at the limit, zero flag, underflow pulse on a stray return.
// Ports: clk/rst, i_inc, i_dec -> o_full, o_zero, o_udf.
module nv_nvdla_cdma_wt_outstd_cnt #(
  parameter int MAX_OUTSTD = 128,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  output logic o_full,
  output logic o_zero,
  output logic o_udf
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign o_zero = (r_cnt == '0);
  assign o_full = (r_cnt == CNT_W'(MAX_OUTSTD));
  assign o_udf  = i_dec & o_zero;

  // Issue and return in the same cycle cancel out.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_inc && !i_dec)
      w_cnt_nxt = r_cnt + 1'b1;
    else if (!i_inc && i_dec && !o_zero)
      w_cnt_nxt = r_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else
      r_cnt <= w_cnt_nxt;
  end

  a_cnt_le_max: assert property (
    @(posedge clk) disable iff (rst)
    r_cnt <= CNT_W'(MAX_OUTSTD));

endmodule

// File: rtl/nv_nvdla_cdma_wt_rd_req_mux.sv
// Weight/WMB read-request mux behind a strict-priority 2:1 arbiter:
// one-entry registered output stage to DMA, per-source outstanding
// throttling, idle and sticky underflow-error status.
// Ports: src0/src1 req handshakes, arb req/gnt/busy, dma_rd_req_*,
// dma_rsp_done0/1, mux_idle, outstd_err.
module nv_nvdla_cdma_wt_rd_req_mux
  import nv_nvdla_cdma_wt_rd_req_mux_pkg::*;
#(
  parameter int PD_W       = CDMA_WT_RD_PD_W,
  parameter int MAX_OUTSTD = CDMA_WT_MAX_OUTSTD,
  parameter int CNT_W      = $clog2(MAX_OUTSTD + 1)
) (
  input  logic            nvdla_core_clk,
  input  logic            nvdla_core_rst,
  input  logic            src0_req_valid,
  output logic            src0_req_ready,
  input  logic [PD_W-1:0] src0_req_pd,
  input  logic            src1_req_valid,
  output logic            src1_req_ready,
  input  logic [PD_W-1:0] src1_req_pd,
  output logic            arb_req0,
  output logic            arb_req1,
  input  logic            arb_gnt0,
  input  logic            arb_gnt1,
  output logic            arb_gnt_busy,
  output logic            dma_rd_req_valid,
  input  logic            dma_rd_req_ready,
  output logic [PD_W-1:0] dma_rd_req_pd,
  output logic            dma_rd_req_src,
  input  logic            dma_rsp_done0,
  input  logic            dma_rsp_done1,
  output logic            mux_idle,
  output logic            outstd_err
);

  logic            r_valid;
  logic [PD_W-1:0] r_pd;
  logic            r_src;
  logic            r_err;

  logic w_take;
  logic w_slot_free;
  logic w_full0, w_full1;
  logic w_zero0, w_zero1;
  logic w_udf0, w_udf1;

  assign w_slot_free  = !r_valid | dma_rd_req_ready;
  assign arb_gnt_busy = !w_slot_free;

  // A full source is masked so the other one can still win.
  assign arb_req0 = src0_req_valid & !w_full0;
  assign arb_req1 = src1_req_valid & !w_full1;

  assign src0_req_ready = arb_gnt0;
  assign src1_req_ready = arb_gnt1;
  assign w_take         = arb_gnt0 | arb_gnt1;

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      r_valid <= 1'b0;
      r_pd    <= '0;
      r_src   <= SRC_WT;
      r_err   <= 1'b0;
    end else begin
      if (w_take) begin
        r_valid <= 1'b1;
        r_pd    <= arb_gnt1 ? src1_req_pd : src0_req_pd;
        r_src   <= arb_gnt1 ? SRC_WMB : SRC_WT;
      end else if (dma_rd_req_ready) begin
        r_valid <= 1'b0;
      end
      r_err <= r_err | w_udf0 | w_udf1;
    end
  end

  nv_nvdla_cdma_wt_outstd_cnt #(
    .MAX_OUTSTD (MAX_OUTSTD),
    .CNT_W      (CNT_W)
  ) u_cnt0 (
    .clk    (nvdla_core_clk),
    .rst    (nvdla_core_rst),
    .i_inc  (arb_gnt0),
    .i_dec  (dma_rsp_done0),
    .o_full (w_full0),
    .o_zero (w_zero0),
    .o_udf  (w_udf0)
  );

  nv_nvdla_cdma_wt_outstd_cnt #(
    .MAX_OUTSTD (MAX_OUTSTD),
    .CNT_W      (CNT_W)
  ) u_cnt1 (
    .clk    (nvdla_core_clk),
    .rst    (nvdla_core_rst),
    .i_inc  (arb_gnt1),
    .i_dec  (dma_rsp_done1),
    .o_full (w_full1),
    .o_zero (w_zero1),
    .o_udf  (w_udf1)
  );

  assign dma_rd_req_valid = r_valid;
  assign dma_rd_req_pd    = r_pd;
  assign dma_rd_req_src   = r_src;
  assign outstd_err       = r_err;
  assign mux_idle         = !r_valid & w_zero0 & w_zero1;

  a_gnt_onehot0: assert property (
    @(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    !(arb_gnt0 && arb_gnt1));

  a_no_take_when_busy: assert property (
    @(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
    !(w_take && !w_slot_free));

endmodule

// File: tb/tb_nv_nvdla_cdma_wt_rd_req_mux.sv
// Bench for the weight read-request mux with a strict-priority
// arbiter model; vector table plus reset/underflow sequences.
module tb_nv_nvdla_cdma_wt_rd_req_mux;

  localparam int PD_W = 79;
  localparam int MAXO = 4;
  localparam int CW   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            v0, v1, rdy, d0, d1;
  logic [PD_W-1:0] p0, p1;
  logic            r0, r1, q0, q1, g0, g1, busy;
  logic            ov, osrc, idle, err;
  logic [PD_W-1:0] opd;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign g0 = q0 & !busy;
  assign g1 = q1 & !q0 & !busy;

  nv_nvdla_cdma_wt_rd_req_mux #(
    .PD_W       (PD_W),
    .MAX_OUTSTD (MAXO),
    .CNT_W      (CW)
  ) dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .src0_req_valid   (v0),
    .src0_req_ready   (r0),
    .src0_req_pd      (p0),
    .src1_req_valid   (v1),
    .src1_req_ready   (r1),
    .src1_req_pd      (p1),
    .arb_req0         (q0),
    .arb_req1         (q1),
    .arb_gnt0         (g0),
    .arb_gnt1         (g1),
    .arb_gnt_busy     (busy),
    .dma_rd_req_valid (ov),
    .dma_rd_req_ready (rdy),
    .dma_rd_req_pd    (opd),
    .dma_rd_req_src   (osrc),
    .dma_rsp_done0    (d0),
    .dma_rsp_done1    (d1),
    .mux_idle         (idle),
    .outstd_err       (err)
  );

  typedef struct {
    logic       v0, v1;
    logic [7:0] p0, p1;
    logic       rdy, d0, d1;
    logic       e_r0, e_r1, e_busy, e_q0, e_q1;
    logic       e_v, e_s;
    logic [7:0] e_p;
    logic       e_idle, e_err;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic iv0, logic iv1, logic [7:0] ip0, logic [7:0] ip1,
    logic irdy, logic id0, logic id1,
    logic er0, logic er1, logic eb, logic eq0, logic eq1,
    logic ev, logic es, logic [7:0] ep, logic ei, logic ee);
    vec_t t;
    t.v0 = iv0; t.v1 = iv1; t.p0 = ip0; t.p1 = ip1;
    t.rdy = irdy; t.d0 = id0; t.d1 = id1;
    t.e_r0 = er0; t.e_r1 = er1; t.e_busy = eb;
    t.e_q0 = eq0; t.e_q1 = eq1;
    t.e_v = ev; t.e_s = es; t.e_p = ep;
    t.e_idle = ei; t.e_err = ee;
    return t;
  endfunction

  task automatic chk(string nm, logic [PD_W-1:0] act,
                     logic [PD_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic iv0, logic iv1, logic [7:0] ip0,
                       logic [7:0] ip1, logic irdy,
                       logic id0, logic id1);
    v0 = iv0; v1 = iv1;
    p0 = PD_W'(ip0) | {8'hA5, 71'h0};
    p1 = PD_W'(ip1) | {8'h5A, 71'h0};
    rdy = irdy; d0 = id0; d1 = id1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("rst_valid", ov, 0);
    chk("rst_pd", opd, 0);
    chk("rst_src", osrc, 0);
    chk("rst_idle", idle, 1);
    chk("rst_err", err, 0);
    chk("rst_r0", r0, 0);
    chk("rst_r1", r1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_q0", q0, 0);
    chk("rst_q1", q1, 0);

    //          v0 v1 p0    p1    rdy d0 d1 r0 r1 bz q0 q1 V S P     idl err
    // src0 priority, back-to-back, fills cnt0 to 4
    tv.push_back(mk(1,1,8'h10,8'h20,1,0,0, 1,0,0,1,1, 1,0,8'h10,0,0));
    tv.push_back(mk(1,1,8'h11,8'h20,1,0,0, 1,0,0,1,1, 1,0,8'h11,0,0));
    tv.push_back(mk(1,1,8'h12,8'h20,1,0,0, 1,0,0,1,1, 1,0,8'h12,0,0));
    tv.push_back(mk(1,1,8'h13,8'h20,1,0,0, 1,0,0,1,1, 1,0,8'h13,0,0));
    // src0 full -> src1 granted; done0 frees src0
    tv.push_back(mk(1,1,8'h13,8'h20,1,0,0, 0,1,0,0,1, 1,1,8'h20,0,0));
    tv.push_back(mk(1,1,8'h13,8'h21,1,1,0, 0,1,0,0,1, 1,1,8'h21,0,0));
    tv.push_back(mk(1,1,8'h14,8'h22,1,0,0, 1,0,0,1,1, 1,0,8'h14,0,0));
    // take of src1 with done1 in same cycle (cnt1 stays 2)
    tv.push_back(mk(1,1,8'h14,8'h22,1,0,1, 0,1,0,0,1, 1,1,8'h22,0,0));
    // DMA stalls 3 cycles: entry held
    tv.push_back(mk(1,1,8'h15,8'h23,0,1,0, 0,0,1,0,1, 1,1,8'h22,0,0));
    tv.push_back(mk(1,1,8'h15,8'h23,0,0,0, 0,0,1,1,1, 1,1,8'h22,0,0));
    tv.push_back(mk(1,1,8'h15,8'h23,0,0,0, 0,0,1,1,1, 1,1,8'h22,0,0));
    tv.push_back(mk(1,1,8'h15,8'h23,1,0,0, 1,0,0,1,1, 1,0,8'h15,0,0));
    // ready without take -> valid drops
    tv.push_back(mk(0,0,8'h00,8'h00,1,0,0, 0,0,0,0,0, 0,0,8'h00,0,0));
    // drain cnt0=4, cnt1=2
    tv.push_back(mk(0,0,8'h00,8'h00,1,1,1, 0,0,0,0,0, 0,0,8'h00,0,0));
    tv.push_back(mk(0,0,8'h00,8'h00,1,1,1, 0,0,0,0,0, 0,0,8'h00,0,0));
    tv.push_back(mk(0,0,8'h00,8'h00,1,1,0, 0,0,0,0,0, 0,0,8'h00,0,0));
    tv.push_back(mk(0,0,8'h00,8'h00,1,1,0, 0,0,0,0,0, 0,0,8'h00,1,0));
    // stray done0 -> sticky error
    tv.push_back(mk(0,0,8'h00,8'h00,1,1,0, 0,0,0,0,0, 0,0,8'h00,1,1));
    tv.push_back(mk(0,0,8'h00,8'h00,1,0,0, 0,0,0,0,0, 0,0,8'h00,1,1));

    foreach (tv[i]) begin
      drive(tv[i].v0, tv[i].v1, tv[i].p0, tv[i].p1,
            tv[i].rdy, tv[i].d0, tv[i].d1);
      #2;
      chk($sformatf("v%0d_r0", i), r0, tv[i].e_r0);
      chk($sformatf("v%0d_r1", i), r1, tv[i].e_r1);
      chk($sformatf("v%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("v%0d_q0", i), q0, tv[i].e_q0);
      chk($sformatf("v%0d_q1", i), q1, tv[i].e_q1);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), ov, tv[i].e_v);
      if (tv[i].e_v) begin
        chk($sformatf("v%0d_src", i), osrc, tv[i].e_s);
        chk($sformatf("v%0d_pd", i), opd,
            PD_W'(tv[i].e_p) |
            (tv[i].e_s ? {8'h5A, 71'h0} : {8'hA5, 71'h0}));
      end
      chk($sformatf("v%0d_idle", i), idle, tv[i].e_idle);
      chk($sformatf("v%0d_err", i), err, tv[i].e_err);
    end

    // reset while an entry is held
    drive(0, 1, 8'h00, 8'h30, 0, 0, 0);
    @(posedge clk); #1;
    chk("hold_valid", ov, 1);
    chk("hold_src", osrc, 1);
    drive(0, 0, 8'h00, 8'h00, 0, 0, 0);
    #2;
    chk("hold_busy", busy, 1);
    @(posedge clk); #1;
    chk("hold_pd", opd, PD_W'(8'h30) | {8'h5A, 71'h0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_valid", ov, 0);
    chk("mrst_pd", opd, 0);
    chk("mrst_src", osrc, 0);
    chk("mrst_err", err, 0);
    chk("mrst_idle", idle, 1);
    // counter was cleared, so this return is stray
    drive(0, 0, 8'h00, 8'h00, 1, 0, 1);
    @(posedge clk); #1;
    drive(0, 0, 8'h00, 8'h00, 1, 0, 0);
    chk("post_rst_err", err, 1);
    chk("post_rst_idle", idle, 1);
    @(posedge clk); #1;
    chk("post_rst_err_sticky", err, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
